// File: rtl/game_pkg.sv
// Shared types, widths and helpers for the Bricks game-flow controller.
package game_pkg;

  localparam int BRICK_COUNT = 56;
  localparam int CNT_W       = 8;
  localparam int LIVES_W     = 2;
  localparam int LEVEL_W     = 2;

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LOST  = 3'd4,
    ST_CLEAR = 3'd5,
    ST_OVER  = 3'd6
  } state_e;

  // Ticks per ball step at a given level; the floor also guards against underflow.
  function automatic logic [CNT_W-1:0] step_period(input int base, input int step,
                                                   input int floor_p,
                                                   input logic [LEVEL_W-1:0] level);
    int red;
    red = int'(level) * step;
    if (red + floor_p >= base) return CNT_W'(floor_p);
    return CNT_W'(base - red);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its keypad/divider and game-object neighbours.
interface game_sequencer_if;
  import game_pkg::*;

  // No valid/ready backpressure: tick, step_en, serve and bricks_reload are one-clock
  // strobes that are consumed on the clock they are high; start and ball_lost are levels.
  logic                   tick;
  logic                   start;
  logic                   ball_lost;
  logic [BRICK_COUNT-1:0] bricks;
  logic                   step_en;
  logic                   serve;
  logic                   bricks_reload;
  logic [LIVES_W-1:0]     lives;
  logic [LEVEL_W-1:0]     level;
  logic [2:0]             state;

  modport master (
    output tick, start, ball_lost, bricks,
    input  step_en, serve, bricks_reload, lives, level, state
  );

  modport slave (
    input  tick, start, ball_lost, bricks,
    output step_en, serve, bricks_reload, lives, level, state
  );

endinterface

// File: rtl/game_sequencer_step_timer.sv
// Divides the 100 Hz tick down to ball/plate step pulses while play is running.
module step_timer
  import game_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             step_en
);

  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             step_q, step_d;

  always_comb begin
    step_cnt_d = step_cnt_q;
    step_d     = 1'b0;
    if (clear) begin
      step_cnt_d = '0;
    end else if (run && tick) begin
      if (step_cnt_q == period - 1'b1) begin
        step_cnt_d = '0;
        step_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_cnt_q <= '0;
      step_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
    end
  end

  // A step due on the tick that ended play is dropped rather than leaking into LOST/CLEAR/OVER.
  assign step_en = step_q & run;

endmodule

// File: rtl/game_sequencer.sv
// Bricks game-flow FSM: serve/play/pause/lost/clear/over, lives, level and step pacing.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int SERVE_TICKS = 100,
  parameter int PAUSE_TICKS = 100,
  parameter int BASE_PERIOD = 50,
  parameter int PERIOD_STEP = 10,
  parameter int MIN_PERIOD  = 10
) (
  input logic              clock,
  input logic              reset,
  game_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               start_q;
  logic               serve_q, serve_d;
  logic               reload_q, reload_d;
  logic               start_rise;
  logic               bricks_empty;
  logic               step_clear;
  logic [CNT_W-1:0]   period;

  assign start_rise   = bus.start & ~start_q;
  assign bricks_empty = (bus.bricks == '0);
  assign period       = step_period(BASE_PERIOD, PERIOD_STEP, MIN_PERIOD, level_q);

  // start_q resets high so a key already held at reset is not seen as a press.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lives_q  <= '0;
      level_q  <= '0;
      start_q  <= 1'b1;
      serve_q  <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lives_q  <= lives_d;
      level_q  <= level_d;
      start_q  <= bus.start;
      serve_q  <= serve_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_rise) state_d = ST_SERVE;
      ST_SERVE: if (bus.tick && cnt_q == SERVE_LAST) state_d = ST_PLAY;
      ST_PLAY: begin
        // Clearing the wall wins over losing the ball on the same tick.
        if (bus.tick && bricks_empty)       state_d = ST_CLEAR;
        else if (bus.tick && bus.ball_lost) state_d = (lives_q == 2'd1) ? ST_OVER : ST_LOST;
        else if (start_rise)                state_d = ST_PAUSE;
      end
      ST_PAUSE: if (start_rise) state_d = ST_PLAY;
      ST_LOST,
      ST_CLEAR: if (bus.tick && cnt_q == PAUSE_LAST) state_d = ST_SERVE;
      ST_OVER:  if (start_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : (bus.tick ? cnt_q + 1'b1 : cnt_q);
  end

  always_comb begin
    lives_d    = lives_q;
    level_d    = level_q;
    serve_d    = 1'b0;
    reload_d   = 1'b0;
    step_clear = (state_q == ST_SERVE) && (state_d == ST_PLAY);
    if (state_q == ST_IDLE && state_d == ST_SERVE) begin
      lives_d  = LIVES_LOAD;
      level_d  = '0;
      reload_d = 1'b1;
    end
    if (state_q != ST_SERVE && state_d == ST_SERVE) serve_d = 1'b1;
    if (state_q == ST_PLAY && (state_d == ST_LOST || state_d == ST_OVER))
      lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
    if (state_q == ST_CLEAR && state_d == ST_SERVE) begin
      level_d  = (level_q == MAX_LEVEL) ? level_q : level_q + 1'b1;
      reload_d = 1'b1;
    end
  end

  step_timer u_step_timer (
    .clock   (clock),
    .reset   (reset),
    .tick    (bus.tick),
    .run     (state_q == ST_PLAY),
    .clear   (step_clear),
    .period  (period),
    .step_en (bus.step_en)
  );

  assign bus.serve         = serve_q;
  assign bus.bricks_reload = reload_q;
  assign bus.lives         = lives_q;
  assign bus.level         = level_q;
  assign bus.state         = state_q;

endmodule
